// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Purpose:
//   Sequences instruction fetch between the IF stage and a variable-latency
//   instruction memory using a req/gnt/rvalid handshake. Only one request is
//   ever outstanding. The PC is held (pc_stall_o) until the fetched
//   instruction has been returned and accepted by the IF/ID register. A
//   branch/jump redirect kills the in-flight fetch, and the stale response
//   is discarded when it eventually arrives.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles spent waiting for rvalid (WAIT/KILL) before the
//                   sticky fetch_timeout_o flag sets; 0 disables the check
//   CNT_W           width of the timeout counter; must be able to hold
//                   TIMEOUT_CYCLES
//
// Ports:
//   clk              in   clock
//   rst_n            in   asynchronous reset, active-low
//   pc_i             in   current PC from the IF stage
//   redirect_i       in   branch taken or jump taken in EX
//   id_ready_i       in   IF/ID register can accept an instruction
//   mem_req_o        out  fetch request to instruction memory
//   mem_addr_o       out  fetch address (combinationally equal to pc_i)
//   mem_gnt_i        in   memory accepted the request this cycle
//   mem_rvalid_i     in   read data valid this cycle
//   mem_rdata_i      in   read data
//   instr_o          out  registered instruction to IF/ID
//   instr_valid_o    out  instr_o is valid
//   pc_stall_o       out  1 = IF stage must hold its PC
//   fetch_timeout_o  out  sticky timeout error flag
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic        redirect_i,
    input  logic        id_ready_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        pc_stall_o,
    output logic        fetch_timeout_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_KILL
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_instr;
    logic             r_instrValid;
    logic             r_timeout;

    logic             w_waiting;
    logic             w_capture;
    logic             w_release;
    logic             w_countTick;
    logic             w_timeoutHit;

    // A response is only accepted in WAIT when no redirect arrives in the
    // same cycle; in KILL every response is stale by construction.
    assign w_waiting    = (r_state == ST_WAIT) || (r_state == ST_KILL);
    assign w_capture    = (r_state == ST_WAIT) && mem_rvalid_i && !redirect_i;
    assign w_release    = (r_state == ST_HOLD) && (redirect_i || id_ready_i);
    assign w_countTick  = w_waiting && !mem_rvalid_i;
    assign w_timeoutHit = (TIMEOUT_CYCLES != 0) && w_countTick && (r_cnt == CNT_LAST);

    // The stall must drop on a redirect in every state, because the IF stage
    // ignores a redirect while it is stalled.
    assign pc_stall_o    = ~(redirect_i | ((r_state == ST_HOLD) & id_ready_i));
    assign mem_req_o     = (r_state == ST_REQ);
    assign mem_addr_o    = pc_i;
    assign instr_o         = r_instr;
    assign instr_valid_o   = r_instrValid;
    assign fetch_timeout_o = r_timeout;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. A redirect while a request is still ungranted just
    // leaves us in REQ; the address follows pc_i, which updates next cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = ST_REQ;
            ST_REQ: begin
                if (mem_gnt_i) begin
                    w_next = redirect_i ? ST_KILL : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    w_next = redirect_i ? ST_REQ : ST_HOLD;
                end else if (redirect_i) begin
                    w_next = ST_KILL;
                end
            end
            ST_KILL: begin
                if (mem_rvalid_i) begin
                    w_next = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect_i || id_ready_i) begin
                    w_next = ST_REQ;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Instruction register and its valid flag. The data is kept after the
    // valid flag drops; only the flag tells IF/ID whether it is meaningful.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr      <= '0;
            r_instrValid <= 1'b0;
        end else begin
            if (w_capture) begin
                r_instr      <= mem_rdata_i;
                r_instrValid <= 1'b1;
            end else if (w_release) begin
                r_instrValid <= 1'b0;
            end
        end
    end

    // Timeout counter: counts WAIT/KILL cycles without a response. Leaving
    // those states always coincides with rvalid, so rvalid clears it. The
    // counter saturates so it can never wrap back onto the trigger value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!w_countTick) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Sticky timeout flag; the FSM keeps waiting regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else if (w_timeoutHit) begin
            r_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//
// Purpose:
//   Self-checking bench for imem_fetch_ctrl (TIMEOUT_CYCLES = 4). A table of
//   per-cycle vectors walks the basic fetch, HOLD back-pressure and redirect
//   cases; hand-written sequences cover timeout and reset mid-fetch; a
//   randomized run is compared against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i;
    logic        redirect_i;
    logic        id_ready_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        pc_stall_o;
    logic        fetch_timeout_o;

    int nChecks = 0;
    int nFails  = 0;

    imem_fetch_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pc_i(pc_i),
        .redirect_i(redirect_i),
        .id_ready_i(id_ready_i),
        .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i),
        .instr_o(instr_o),
        .instr_valid_o(instr_valid_o),
        .pc_stall_o(pc_stall_o),
        .fetch_timeout_o(fetch_timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        red;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        expReq;
        logic        expStall;
        logic        expValid;
        logic [31:0] expInstr;
    } vec_t;

    vec_t vecs[21];

    // Reference model state: what the fetch unit is doing, in transaction terms.
    bit          mIdle;
    bit          mReq;
    bit          mPend;
    bit          mStale;
    bit          mHave;
    bit          mTo;
    logic [31:0] mInstr;
    int          mWait;

    // Single comparison; every mismatch reports one FAIL line.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, settle, then return so
    // the caller can sample mid-cycle.
    task automatic applyStimulus(input logic [31:0] pc, input logic red, input logic gnt,
                                 input logic rv, input logic [31:0] rd, input logic rdy);
        @(negedge clk);
        pc_i         = pc;
        redirect_i   = red;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
        id_ready_i   = rdy;
        #1;
    endtask

    task automatic checkAll(input string tag, input logic req, input logic stall,
                            input logic valid, input logic [31:0] instr, input logic to);
        checkOutput($sformatf("%s.req", tag), {31'b0, mem_req_o}, {31'b0, req});
        checkOutput($sformatf("%s.addr", tag), mem_addr_o, pc_i);
        checkOutput($sformatf("%s.stall", tag), {31'b0, pc_stall_o}, {31'b0, stall});
        checkOutput($sformatf("%s.valid", tag), {31'b0, instr_valid_o}, {31'b0, valid});
        checkOutput($sformatf("%s.instr", tag), instr_o, instr);
        checkOutput($sformatf("%s.timeout", tag), {31'b0, fetch_timeout_o}, {31'b0, to});
    endtask

    // Reset is released just after a rising edge so the next applyStimulus
    // lands in the IDLE cycle.
    task automatic doReset();
        rst_n        = 1'b0;
        pc_i         = '0;
        redirect_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        id_ready_i   = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic modelReset();
        mIdle  = 1'b1;
        mReq   = 1'b0;
        mPend  = 1'b0;
        mStale = 1'b0;
        mHave  = 1'b0;
        mTo    = 1'b0;
        mInstr = '0;
        mWait  = 0;
    endtask

    // Advance the model across one rising edge using this cycle's inputs.
    task automatic modelStep(input logic red, input logic gnt, input logic rv,
                             input logic [31:0] rd, input logic rdy);
        if (mIdle) begin
            mIdle = 1'b0;
            mReq  = 1'b1;
        end else if (mReq) begin
            if (gnt) begin
                mReq   = 1'b0;
                mPend  = 1'b1;
                mStale = red;
                mWait  = 0;
            end
        end else if (mPend) begin
            if (rv) begin
                mPend = 1'b0;
                mWait = 0;
                if (mStale || red) begin
                    mReq = 1'b1;
                end else begin
                    mHave  = 1'b1;
                    mInstr = rd;
                end
            end else begin
                if (red) mStale = 1'b1;
                if (mWait == TO - 1) mTo = 1'b1;
                mWait++;
            end
        end else if (mHave) begin
            if (rdy || red) begin
                mHave = 1'b0;
                mReq  = 1'b1;
            end
        end
    endtask

    initial begin
        // pc, red, gnt, rv, rdata, rdy | req, stall, valid, instr
        vecs[0]  = '{32'h000, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{32'h000, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{32'h000, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{32'h000, 1'b0, 1'b0, 1'b1, 32'h00500093, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{32'h000, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h00500093};
        vecs[5]  = '{32'h004, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h00500093};
        vecs[6]  = '{32'h004, 1'b0, 1'b0, 1'b1, 32'h00A00113, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00500093};
        vecs[7]  = '{32'h004, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h00A00113};
        vecs[8]  = '{32'h004, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00A00113};
        vecs[9]  = '{32'h004, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h00A00113};
        vecs[10] = '{32'h004, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h00A00113};
        vecs[11] = '{32'h004, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h00A00113};
        vecs[12] = '{32'h008, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h00A00113};
        vecs[13] = '{32'h008, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h00A00113};
        vecs[14] = '{32'h100, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00A00113};
        vecs[15] = '{32'h100, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h00A00113};
        vecs[16] = '{32'h200, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h00A00113};
        vecs[17] = '{32'h200, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00A00113};
        vecs[18] = '{32'h200, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h00A00113};
        vecs[19] = '{32'h200, 1'b1, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00A00113};
        vecs[20] = '{32'h300, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h00A00113};

        doReset();

        // Table: basic fetch, HOLD back-pressure, redirect in WAIT/REQ+gnt/WAIT+rvalid.
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].pc, vecs[i].red, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].rdy);
            checkAll($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expStall,
                     vecs[i].expValid, vecs[i].expInstr, 1'b0);
        end

        // Timeout: four WAIT cycles without rvalid set the sticky flag.
        doReset();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("to.idle", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkAll("to.req", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int w = 1; w <= 4; w++) begin
            applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            checkAll($sformatf("to.wait%0d", w), 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        end
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 32'h00000013, 1'b0);
        checkAll("to.set", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkAll("to.hold", 1'b0, 1'b1, 1'b1, 32'h00000013, 1'b1);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("to.accept", 1'b0, 1'b0, 1'b1, 32'h00000013, 1'b1);
        applyStimulus(32'h4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkAll("to.sticky", 1'b1, 1'b1, 1'b0, 32'h00000013, 1'b1);

        // Reset mid-WAIT, then a late rvalid in IDLE must be ignored.
        applyStimulus(32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("rst.wait", 1'b0, 1'b1, 1'b0, 32'h00000013, 1'b1);
        rst_n = 1'b0;
        #1;
        checkAll("rst.asserted", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 32'hBAADF00D, 1'b1);
        checkAll("rst.idle", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkAll("rst.req", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 32'h00100073, 1'b1);
        checkAll("rst.wait2", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("rst.hold", 1'b0, 1'b0, 1'b1, 32'h00100073, 1'b0);

        // Randomized run against the reference model.
        doReset();
        modelReset();
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] pc;
            logic [31:0] rd;
            logic        red;
            logic        gnt;
            logic        rv;
            logic        rdy;
            pc  = $urandom;
            rd  = $urandom;
            red = ($urandom_range(0, 5) == 0);
            gnt = 1'($urandom_range(0, 1));
            rv  = ($urandom_range(0, 2) == 0);
            rdy = 1'($urandom_range(0, 1));
            applyStimulus(pc, red, gnt, rv, rd, rdy);
            checkAll($sformatf("rnd%0d", c), mReq, !(red || (mHave && rdy)), mHave, mInstr, mTo);
            modelStep(red, gnt, rv, rd, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
